// File: rtl/cpu_regfile.sv
// cpu_regfile: architectural register file (A F B C D E H L SP PC).
// Combinational 8-bit and 16-bit pair reads; 8-bit, pair and flag writes;
// a one-cycle inc/dec unit on a pair; a dedicated PC port with load and
// increment.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, rd8, rd16 and
// flags forward same-edge write data (wr16, wr8, flags). IDU results and
// the PC are never forwarded.
module cpu_regfile #(
  parameter logic [15:0] SP_RESET = 16'hFFFE,
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rd8_sel,
  output logic [7:0]  rd8,
  input  logic [1:0]  rd16_sel,
  output logic [15:0] rd16,
  input  logic [2:0]  wr8_sel,
  input  logic [7:0]  wr8_data,
  input  logic        wr8_en,
  input  logic [1:0]  wr16_sel,
  input  logic [15:0] wr16_data,
  input  logic        wr16_en,
  input  logic [1:0]  idu_sel,
  input  logic [1:0]  idu_op,
  input  logic [3:0]  flags_in,
  input  logic        flags_we,
  output logic [3:0]  flags,
  input  logic [15:0] pc_wr,
  input  logic        pc_we,
  input  logic        pc_inc,
  output logic [15:0] pc
);

  // Byte slots 0..7 follow the rd8_sel encoding (B C D E H L F A);
  // slots 8 and 9 are SP high and SP low.
  localparam int NUM_BYTES = 10;
  localparam logic [3:0] F_IDX = 4'd6;

  logic [7:0]  regs   [NUM_BYTES];
  logic [7:0]  wr_val [NUM_BYTES];
  logic [7:0]  view   [NUM_BYTES];
  logic [NUM_BYTES-1:0] wr_hit;
  logic [NUM_BYTES-1:0] idu_hit;
  logic [15:0] idu_cur;
  logic [15:0] idu_res;
  logic        idu_act;
  logic [15:0] pc_q;

  // Slot of the high / low byte of a pair (0 BC, 1 DE, 2 HL, 3 SP).
  function automatic logic [3:0] hi_idx(input logic [1:0] p);
    return (p == 2'd3) ? 4'd8 : {1'b0, p, 1'b0};
  endfunction

  function automatic logic [3:0] lo_idx(input logic [1:0] p);
    return (p == 2'd3) ? 4'd9 : {1'b0, p, 1'b1};
  endfunction

  // IDU: read the target pair and apply +/-1 modulo 2^16.
  always_comb begin
    idu_cur = {regs[hi_idx(idu_sel)], regs[lo_idx(idu_sel)]};
    idu_act = 1'b0;
    idu_res = idu_cur;
    case (idu_op)
      2'b01: begin
        idu_act = 1'b1;
        idu_res = idu_cur + 16'd1;
      end
      2'b10: begin
        idu_act = 1'b1;
        idu_res = idu_cur - 16'd1;
      end
      default: ;
    endcase
  end

  // Port writes per byte, applied lowest priority first so that later
  // (higher priority) sources overwrite: flags, then wr8, then wr16.
  // NOTE: every output of this block gets a value before any conditional
  // update, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      wr_val[i] = regs[i];
    end
    wr_hit = '0;
    if (flags_we) begin
      wr_val[F_IDX] = {flags_in, 4'h0};
      wr_hit[F_IDX] = 1'b1;
    end
    if (wr8_en) begin
      // F's low nibble is hard-wired to zero.
      wr_val[{1'b0, wr8_sel}] = ({1'b0, wr8_sel} == F_IDX) ?
                                {wr8_data[7:4], 4'h0} : wr8_data;
      wr_hit[{1'b0, wr8_sel}] = 1'b1;
    end
    if (wr16_en) begin
      wr_val[hi_idx(wr16_sel)] = wr16_data[15:8];
      wr_val[lo_idx(wr16_sel)] = wr16_data[7:0];
      wr_hit[hi_idx(wr16_sel)] = 1'b1;
      wr_hit[lo_idx(wr16_sel)] = 1'b1;
    end
  end

  // IDU owns only the bytes of its pair that no port write claims.
  always_comb begin
    idu_hit = '0;
    if (idu_act) begin
      idu_hit[hi_idx(idu_sel)] = 1'b1;
      idu_hit[lo_idx(idu_sel)] = 1'b1;
    end
  end

  // Register bytes: reset to architectural values, else take the winner.
  // NOTE: this array is a bank of flops, not a RAM, so resetting every
  // entry is intended and cheap; a RAM-inferred memory would not be reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 8'h00;
      end
      regs[8] <= SP_RESET[15:8];
      regs[9] <= SP_RESET[7:0];
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_val[i];
        end else if (idu_hit[i]) begin
          regs[i] <= (i[0] == 1'b0 && i != 9) ? idu_res[15:8] : idu_res[7:0];
        end
      end
    end
  end

  // Program counter: load beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else if (pc_we) begin
      pc_q <= pc_wr;
    end else if (pc_inc) begin
      pc_q <= pc_q + 16'd1;
    end
  end

  // Read view: registered state, or same-edge port writes when forwarding.
  always_comb begin
    for (int i = 0; i < NUM_BYTES; i++) begin
`ifdef REGFILE_BYPASS_EN
      view[i] = wr_val[i];
`else
      view[i] = regs[i];
`endif
    end
  end

  // Output muxes.
  always_comb begin
    rd8   = view[{1'b0, rd8_sel}];
    rd16  = {view[hi_idx(rd16_sel)], view[lo_idx(rd16_sel)]};
    flags = view[F_IDX][7:4];
    pc    = pc_q;
  end

endmodule

// File: tb/tb_cpu_regfile.sv
// Self-checking bench for cpu_regfile: directed cases for reset, pair/byte
// aliasing, IDU wrap, write conflicts, PC and read forwarding, followed by
// randomized traffic compared against a behavioural model.
module tb_cpu_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  rd8_sel;
  logic [7:0]  rd8;
  logic [1:0]  rd16_sel;
  logic [15:0] rd16;
  logic [2:0]  wr8_sel;
  logic [7:0]  wr8_data;
  logic        wr8_en;
  logic [1:0]  wr16_sel;
  logic [15:0] wr16_data;
  logic        wr16_en;
  logic [1:0]  idu_sel;
  logic [1:0]  idu_op;
  logic [3:0]  flags_in;
  logic        flags_we;
  logic [3:0]  flags;
  logic [15:0] pc_wr;
  logic        pc_we;
  logic        pc_inc;
  logic [15:0] pc;

  cpu_regfile dut (
    .clk(clk), .rst(rst),
    .rd8_sel(rd8_sel), .rd8(rd8),
    .rd16_sel(rd16_sel), .rd16(rd16),
    .wr8_sel(wr8_sel), .wr8_data(wr8_data), .wr8_en(wr8_en),
    .wr16_sel(wr16_sel), .wr16_data(wr16_data), .wr16_en(wr16_en),
    .idu_sel(idu_sel), .idu_op(idu_op),
    .flags_in(flags_in), .flags_we(flags_we), .flags(flags),
    .pc_wr(pc_wr), .pc_we(pc_we), .pc_inc(pc_inc), .pc(pc)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: bytes indexed B C D E H L F A, SP and PC as 16-bit numbers.
  logic [7:0]  m_r [8];
  logic [15:0] m_sp, m_pc;
  logic [7:0]  n_r [8];
  logic [15:0] n_sp, n_pc;
  logic [7:0]  v_r [8];
  logic [15:0] v_sp;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_sp = 16'hFFFE;
    m_pc = 16'h0000;
  endtask

  function automatic logic [15:0] m_pair(input logic [1:0] p);
    case (p)
      2'd0: return {m_r[0], m_r[1]};
      2'd1: return {m_r[2], m_r[3]};
      2'd2: return {m_r[4], m_r[5]};
      default: return m_sp;
    endcase
  endfunction

  function automatic logic [15:0] v_pair(input logic [1:0] p);
    case (p)
      2'd0: return {v_r[0], v_r[1]};
      2'd1: return {v_r[2], v_r[3]};
      2'd2: return {v_r[4], v_r[5]};
      default: return v_sp;
    endcase
  endfunction

  task automatic n_set_pair(input logic [1:0] p, input logic [15:0] v);
    case (p)
      2'd0: begin n_r[0] = v[15:8]; n_r[1] = v[7:0]; end
      2'd1: begin n_r[2] = v[15:8]; n_r[3] = v[7:0]; end
      2'd2: begin n_r[4] = v[15:8]; n_r[5] = v[7:0]; end
      default: n_sp = v;
    endcase
  endtask

  // Architectural effect of one edge. The IDU updates the whole pair first,
  // then flags, wr8 and wr16 overwrite bytes in rising priority. With
  // full=0 only the port writes are applied (the forwarded view).
  task automatic calc_next(input bit full);
    logic [15:0] v;
    n_r  = m_r;
    n_sp = m_sp;
    n_pc = m_pc;
    if (full && (idu_op == 2'b01 || idu_op == 2'b10)) begin
      v = m_pair(idu_sel);
      v = (idu_op == 2'b01) ? v + 16'd1 : v - 16'd1;
      n_set_pair(idu_sel, v);
    end
    if (flags_we) n_r[6] = {flags_in, 4'h0};
    if (wr8_en) n_r[wr8_sel] = (wr8_sel == 3'd6) ? {wr8_data[7:4], 4'h0} : wr8_data;
    if (wr16_en) n_set_pair(wr16_sel, wr16_data);
    if (full) begin
      if (pc_we) n_pc = pc_wr;
      else if (pc_inc) n_pc = m_pc + 16'd1;
    end
  endtask

  task automatic clr();
    wr8_en = 0; wr16_en = 0; flags_we = 0; pc_we = 0; pc_inc = 0;
    idu_op = 2'b00;
  endtask

  // Called just after a falling edge with inputs driven: check pre-edge
  // reads, cross the rising edge and advance the model.
  task automatic step();
    #1;
`ifdef REGFILE_BYPASS_EN
    calc_next(0);
    v_r = n_r; v_sp = n_sp;
`else
    v_r = m_r; v_sp = m_sp;
`endif
    check("pre_rd8", rd8, v_r[rd8_sel]);
    check("pre_rd16", rd16, v_pair(rd16_sel));
    check("pre_flags", flags, v_r[6][7:4]);
    check("pre_pc", pc, m_pc);
    calc_next(1);
    @(posedge clk);
    #1;
    m_r = n_r; m_sp = n_sp; m_pc = n_pc;
    clr();
  endtask

  // With all strobes idle, sweep every read select against the model.
  task automatic check_all();
    clr();
    for (int i = 0; i < 8; i++) begin
      rd8_sel = 3'(i);
      #1 check("rd8_all", rd8, m_r[i]);
    end
    for (int p = 0; p < 4; p++) begin
      rd16_sel = 2'(p);
      #1 check("rd16_all", rd16, m_pair(2'(p)));
    end
    check("flags_all", flags, m_r[6][7:4]);
    check("pc_all", pc, m_pc);
  endtask

  task automatic expect8(input string tag, input logic [2:0] sel, input logic [7:0] exp);
    rd8_sel = sel;
    #1 check(tag, rd8, exp);
  endtask

  task automatic expect16(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    rd16_sel = sel;
    #1 check(tag, rd16, exp);
  endtask

  task automatic do_wr16(input logic [1:0] sel, input logic [15:0] d);
    @(negedge clk);
    wr16_en = 1; wr16_sel = sel; wr16_data = d;
    step();
  endtask

  task automatic do_idu(input logic [1:0] sel, input logic [1:0] op);
    @(negedge clk);
    idu_sel = sel; idu_op = op;
    step();
  endtask

  initial begin
    rst = 1'b1;
    rd8_sel = 0; rd16_sel = 0; wr8_sel = 0; wr8_data = 0; wr16_sel = 0;
    wr16_data = 0; idu_sel = 0; flags_in = 0; pc_wr = 0;
    clr();
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    expect16("rst_sp", 2'd3, 16'hFFFE);
    check("rst_pc", pc, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Pair / byte aliasing and F masking.
    do_wr16(2'd2, 16'h1234);
    expect8("hl_hi", 3'd4, 8'h12);
    expect8("hl_lo", 3'd5, 8'h34);
    @(negedge clk);
    wr8_en = 1; wr8_sel = 3'd6; wr8_data = 8'hFF;
    step();
    expect8("f_mask", 3'd6, 8'hF0);
    check("flags_f", flags, 4'hF);

    // IDU wrap and chaining.
    do_wr16(2'd2, 16'hFFFF);
    do_idu(2'd2, 2'b01);
    expect16("hl_wrap", 2'd2, 16'h0000);
    do_wr16(2'd3, 16'h0000);
    do_idu(2'd3, 2'b10);
    expect16("sp_wrap", 2'd3, 16'hFFFF);
    do_wr16(2'd1, 16'h00FF);
    do_idu(2'd1, 2'b01);
    do_idu(2'd1, 2'b01);
    expect16("de_chain", 2'd1, 16'h0101);
    do_idu(2'd1, 2'b11);
    expect16("idu_resv", 2'd1, 16'h0101);

    // Same-edge conflicts.
    @(negedge clk);
    wr16_en = 1; wr16_sel = 2'd0; wr16_data = 16'hAAAA;
    wr8_en = 1; wr8_sel = 3'd1; wr8_data = 8'h55;
    step();
    expect16("bc_wr16_wins", 2'd0, 16'hAAAA);
    @(negedge clk);
    wr8_en = 1; wr8_sel = 3'd6; wr8_data = 8'hA0;
    flags_we = 1; flags_in = 4'b0101;
    step();
    expect8("f_wr8_wins", 3'd6, 8'hA0);
    do_wr16(2'd2, 16'h10FF);
    @(negedge clk);
    idu_sel = 2'd2; idu_op = 2'b01;
    wr8_en = 1; wr8_sel = 3'd4; wr8_data = 8'h77;
    step();
    expect16("hl_split", 2'd2, 16'h7700);
    check_all();

    // PC port.
    @(negedge clk);
    pc_we = 1; pc_wr = 16'hFFFE;
    step();
    @(negedge clk); pc_inc = 1; step(); check("pc_inc1", pc, 16'hFFFF);
    @(negedge clk); pc_inc = 1; step(); check("pc_inc2", pc, 16'h0000);
    @(negedge clk); pc_inc = 1; step(); check("pc_inc3", pc, 16'h0001);
    @(negedge clk);
    pc_we = 1; pc_wr = 16'hC000; pc_inc = 1;
    step();
    check("pc_we_wins", pc, 16'hC000);

    // Forwarding of a same-cycle 8-bit write.
    @(negedge clk);
    wr8_en = 1; wr8_sel = 3'd7; wr8_data = 8'h11;
    step();
    @(negedge clk);
    wr8_en = 1; wr8_sel = 3'd7; wr8_data = 8'h3C; rd8_sel = 3'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("a_before_edge", rd8, 8'h3C);
`else
    check("a_before_edge", rd8, 8'h11);
`endif
    step();
    expect8("a_after_edge", 3'd7, 8'h3C);

    // Asynchronous reset mid-cycle with writes pending.
    @(negedge clk);
    wr16_en = 1; wr16_sel = 2'd0; wr16_data = 16'h5A5A;
    idu_sel = 2'd1; idu_op = 2'b01; pc_inc = 1; rd16_sel = 2'd3;
    #5 rst = 1'b1;
    #1;
    model_reset();
    check("async_pc", pc, 16'h0000);
    check("async_flags", flags, 4'h0);
    check("async_sp", rd16, 16'hFFFE);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    do_wr16(2'd0, 16'hBEEF);
    expect16("post_rst_wr", 2'd0, 16'hBEEF);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      rd8_sel   = 3'($urandom_range(0, 7));
      rd16_sel  = 2'($urandom_range(0, 3));
      wr8_en    = ($urandom_range(0, 2) == 0);
      wr8_sel   = 3'($urandom_range(0, 7));
      wr8_data  = 8'($urandom);
      wr16_en   = ($urandom_range(0, 3) == 0);
      wr16_sel  = 2'($urandom_range(0, 3));
      wr16_data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      idu_op    = 2'($urandom_range(0, 3));
      idu_sel   = 2'($urandom_range(0, 3));
      flags_we  = ($urandom_range(0, 2) == 0);
      flags_in  = 4'($urandom);
      pc_we     = ($urandom_range(0, 7) == 0);
      pc_wr     = 16'($urandom);
      pc_inc    = ($urandom_range(0, 1) == 0);
      step();
      if (k % 10 == 0) check_all();
    end
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_regfile.md
# cpu_regfile

Architectural register file of the VerilogBoy CPU core, built from the single 8-bit register stage and consumed directly by the datapath and ALU. It holds A, F, B, C, D, E, H, L, SP and PC. It provides combinational 8-bit and 16-bit pair reads, and 8-bit, 16-bit and flag writes. An inc/dec unit (IDU) updates a pair in one cycle for HL+/HL-, INC rr/DEC rr and PUSH/POP. A dedicated PC port supports increment and load.

## Interface
- SP_RESET, 16'hFFFE, SP value after reset
- PC_RESET, 16'h0000, PC value after reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd8_sel  in  3  8-bit read select: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 F, 7 A
- rd8  out  8  selected register, combinational
- rd16_sel  in  2  pair read select: 0 BC, 1 DE, 2 HL, 3 SP
- rd16  out  16  selected pair, high byte first register, combinational
- wr8_sel  in  3  8-bit write select, same encoding as rd8_sel
- wr8_data  in  8  8-bit write data
- wr8_en  in  1  8-bit write strobe
- wr16_sel  in  2  pair write select, same encoding as rd16_sel
- wr16_data  in  16  pair write data
- wr16_en  in  1  pair write strobe
- idu_sel  in  2  IDU target pair, same encoding as rd16_sel
- idu_op  in  2  00 none, 01 increment, 10 decrement, 11 reserved (treated as none)
- flags_in  in  4  Z N H C
- flags_we  in  1  flag write strobe
- flags  out  4  F[7:4]
- pc_wr  in  16  PC load value
- pc_we  in  1  PC load strobe
- pc_inc  in  1  PC increment strobe
- pc  out  16  current PC

## Operation
- Reset (async, immediate): A, B, C, D, E, H, L and F = 0; SP = SP_RESET; PC = PC_RESET. Outputs follow at once: flags = 0, pc = PC_RESET, and rd8/rd16 reflect the reset contents.
- F[3:0] reads as 0 at all times. Any write to F masks its low nibble.
- IDU: the target pair is read, 16-bit ±1 is applied modulo 2^16, and the result is written at the clock edge. FFFF+1 = 0000; 0000-1 = FFFF.
- PC: pc_we loads pc_wr. pc_inc adds 1 modulo 2^16. If both are asserted, pc_we wins.
- Same-edge conflicts are resolved per byte, highest priority first:
  1. wr16_en
  2. wr8_en
  3. IDU
  4. flags_we (F only)
- A losing source does not partially update a byte it lost. IDU and wr8 on different bytes of the same pair: IDU writes only the byte wr8 does not own.
- flags_we together with wr8 to F (sel 6): wr8 wins.
- Writes to disjoint registers on the same edge all take effect.
- Reset asserted mid-cycle overrides every pending write. The first edge after rst deasserts performs normal writes.

## Timing
- Reads are combinational from current state. Without bypass, a value written at edge N is visible after edge N.
- All writes take 1 cycle: inputs sampled at the rising edge, state updated at that edge.
- IDU latency is 1 edge. Back-to-back IDU ops on the same pair chain correctly: HL+ twice gives +2 after 2 edges.
- PC increment is 1 per asserted edge. There are no wait states or handshakes. Strobes are level-sampled every edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - rd8, rd16 and flags forward same-cycle write data, applying the priority rules and the F masking.
  - IDU results are not forwarded.
  - pc does not forward.
- REGFILE_BYPASS_EN undefined: reads show registered state only.

## Test plan
- Reset: assert rst with arbitrary prior contents -> immediately rd16(SP)=FFFE, pc=0000, flags=0, rd8 of every register = 00.
- Pair/byte: wr16 HL=1234, then rd8_sel 4 -> 12 and rd8_sel 5 -> 34. wr8 F=FF -> rd8(F)=F0, flags=F.
- IDU wrap: HL=FFFF with idu_op inc -> 0000 next cycle. SP=0000 with dec -> FFFF. Two consecutive inc on DE=00FF -> 0101.
- Conflicts, same edge:
  - wr16 BC=AAAA with wr8 C=55 -> BC=AAAA.
  - wr8 F=A0 with flags_we 0101 -> F=A0.
  - IDU inc HL=10FF with wr8 H=77 -> HL=7700.
- PC: pc_inc for 3 cycles from FFFE -> FFFF, 0000, 0001. pc_we=C000 with pc_inc -> C000.
- Bypass, with macro defined: wr8 A=3C with rd8_sel 7 in the same cycle -> rd8=3C before the edge. Without the macro -> old A before the edge, 3C after.
